// File: rtl/block_mem_writer_pkg.sv
// Shared definitions for block sprite writers and draw units: style codes,
// pixel codes, writer FSM encoding and default block geometry.
package block_mem_writer_pkg;

    localparam int unsigned BLK_W_DEF  = 78;
    localparam int unsigned BLK_H_DEF  = 53;
    localparam int unsigned BORDER_DEF = 2;
    localparam int unsigned AW_DEF     = 13;

    typedef enum logic [1:0] {
        STY_CLEAR  = 2'd0,
        STY_SOLID  = 2'd1,
        STY_BEVEL  = 2'd2,
        STY_HOLLOW = 2'd3
    } style_e;

    // Pixel codes, also used by the draw units' colour mapping
    localparam logic [1:0] PIX_BLACK  = 2'b00;
    localparam logic [1:0] PIX_COLOR  = 2'b01;
    localparam logic [1:0] PIX_HILITE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/block_mem_writer_pattern_gen.sv
// Combinational pattern generator: maps (style, col, row) to a 2-bit pixel code.
module block_pattern_gen
    import block_mem_writer_pkg::*;
#(
    parameter int unsigned BLK_W  = BLK_W_DEF,
    parameter int unsigned BLK_H  = BLK_H_DEF,
    parameter int unsigned BORDER = BORDER_DEF,
    parameter int unsigned CW     = $clog2(BLK_W),
    parameter int unsigned RW     = $clog2(BLK_H)
) (
    input  logic [1:0]    style_i,
    input  logic [CW-1:0] col_i,
    input  logic [RW-1:0] row_i,
    output logic [1:0]    pix_c_o
);

    localparam logic [CW-1:0] COL_LO = CW'(BORDER);
    localparam logic [CW-1:0] COL_HI = CW'(BLK_W - BORDER);
    localparam logic [RW-1:0] ROW_LO = RW'(BORDER);
    localparam logic [RW-1:0] ROW_HI = RW'(BLK_H - BORDER);

    logic   border;
    style_e sty;

    always_comb begin
        border  = (col_i < COL_LO) || (col_i >= COL_HI) ||
                  (row_i < ROW_LO) || (row_i >= ROW_HI);
        sty     = style_e'(style_i);
        pix_c_o = PIX_BLACK;
        case (sty)
            STY_CLEAR:  pix_c_o = PIX_BLACK;
            STY_SOLID:  pix_c_o = PIX_COLOR;
            STY_BEVEL:  pix_c_o = border ? PIX_HILITE : PIX_COLOR;
            STY_HOLLOW: pix_c_o = border ? PIX_HILITE : PIX_BLACK;
            default:    pix_c_o = PIX_BLACK;
        endcase
    end

endmodule

// File: rtl/block_mem_writer.sv
// Fills the block sprite memory with a generated pattern, one pixel per
// vblank cycle, with a start/busy/done handshake to the game controller.
module block_mem_writer
    import block_mem_writer_pkg::*;
#(
    parameter int unsigned BLK_W  = BLK_W_DEF,
    parameter int unsigned BLK_H  = BLK_H_DEF,
    parameter int unsigned BORDER = BORDER_DEF,
    parameter int unsigned AW     = AW_DEF
) (
    input  logic          vclk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    style,
    input  logic          vblank,
    output logic          busy,
    output logic          done,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [1:0]    wdata
);

    localparam int unsigned   NPIX      = BLK_W * BLK_H;
    localparam int unsigned   CW        = $clog2(BLK_W);
    localparam int unsigned   RW        = $clog2(BLK_H);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(BLK_W - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [CW-1:0] col_q,   col_d;
    logic [RW-1:0] row_q,   row_d;
    logic [1:0]    style_q, style_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          we_q,    we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [1:0]    wdata_q, wdata_d;
    logic [1:0]    pix_c;

    block_pattern_gen #(
        .BLK_W  (BLK_W),
        .BLK_H  (BLK_H),
        .BORDER (BORDER),
        .CW     (CW),
        .RW     (RW)
    ) u_pattern (
        .style_i (style_q),
        .col_i   (col_q),
        .row_i   (row_q),
        .pix_c_o (pix_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        style_d = style_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    style_d = style;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (vblank) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (vblank) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = pix_c;
                    // Counters stop on the last pixel so the address never wraps
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d = addr_q + AW'(1);
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            style_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= PIX_BLACK;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            style_q <= style_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_block_mem_writer.sv
// Scoreboard bench for block_mem_writer: stimulus queues expected writes,
// a negedge monitor pops and compares every write and done pulse.
module tb_block_mem_writer;
    import block_mem_writer_pkg::*;

    localparam int unsigned W  = 78;
    localparam int unsigned H  = 53;
    localparam int unsigned NP = W * H;

    logic        vclk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  style;
    logic        vblank;
    logic        busy;
    logic        done;
    logic        we;
    logic [12:0] waddr;
    logic [1:0]  wdata;

    always #5 vclk = ~vclk;

    block_mem_writer dut (
        .vclk   (vclk),
        .rst    (rst),
        .start  (start),
        .style  (style),
        .vblank (vblank),
        .busy   (busy),
        .done   (done),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    typedef struct packed {
        logic [12:0] addr;
        logic [1:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          hi_cnt = 0;
    int          done_cnt = 0;
    int          first_we_cyc = 0;
    int          start_edge = 0;
    logic [1:0]  mem [NP];
    logic        vb_at_edge = 1'b0;
    logic        prev_we = 1'b0;
    logic [12:0] prev_addr = '0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [1:0] exp_pix(input logic [1:0] s, input int c, input int r);
        bit b;
        b = (c < 2) || (c >= 76) || (r < 2) || (r >= 51);
        case (s)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return b ? 2'b11 : 2'b01;
            default: return b ? 2'b11 : 2'b00;
        endcase
    endfunction

    always @(posedge vclk) begin
        cyc        <= cyc + 1;
        vb_at_edge <= vblank;
    end

    // Monitor: every write must match the head of the queue and follow a vblank=1 edge
    always @(negedge vclk) begin
        if (rst === 1'b0) begin
            if (we === 1'b1) begin
                if (wr_cnt == 0) first_we_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_extra actual addr=%0d data=%0d required no write", waddr, wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (waddr !== mon_e.addr || wdata !== mon_e.data || vb_at_edge !== 1'b1) begin
                        errors++;
                        $display("FAIL wr actual addr=%0d data=%0d vb=%0b required addr=%0d data=%0d vb=1",
                                 waddr, wdata, vb_at_edge, mon_e.addr, mon_e.data);
                    end
                end
                if (32'(waddr) < NP) mem[waddr] = wdata;
                if (wdata == 2'b11) hi_cnt++;
                wr_cnt++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                check("done_after_we", int'(prev_we), 1);
                check("done_after_addr", int'(prev_addr), 4133);
                check("busy_at_done", int'(busy), 0);
            end
            prev_we   = we;
            prev_addr = waddr;
        end
    end

    task automatic push_cmd(input logic [1:0] s);
        for (int r = 0; r < int'(H); r++)
            for (int c = 0; c < int'(W); c++)
                exp_q.push_back('{addr: 13'(r * int'(W) + c), data: exp_pix(s, c, r)});
    endtask

    task automatic pulse_start(input logic [1:0] s);
        style      = s;
        start      = 1'b1;
        start_edge = cyc + 1;
        @(posedge vclk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(posedge vclk); #1;
            n++;
        end
        check({name, "_done_seen"}, (done_cnt != d0) ? 1 : 0, 1);
    endtask

    task automatic wait_writes(input int target, input string name);
        int n = 0;
        while (wr_cnt < target && n < 20000) begin
            @(posedge vclk); #1;
            n++;
        end
        check({name, "_writes_reached"}, (wr_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic finish_cmd(input int d0, input string name);
        repeat (4) @(posedge vclk);
        #1;
        check({name, "_write_count"}, wr_cnt, 4134);
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_done_low"}, int'(done), 0);
    endtask

    task automatic begin_cmd(input logic [1:0] s, output int d0);
        wr_cnt = 0;
        hi_cnt = 0;
        d0     = done_cnt;
        push_cmd(s);
        pulse_start(s);
    endtask

    initial begin
        int d0;
        int w0;
        int raise_edge;
        rst    = 1'b1;
        start  = 1'b0;
        style  = 2'd0;
        vblank = 1'b1;
        repeat (3) @(posedge vclk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(we), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_wdata", int'(wdata), 0);
        rst = 1'b0;
        @(posedge vclk); #1;

        // SOLID with vblank held high
        begin_cmd(2'd1, d0);
        check("solid_busy_next", int'(busy), 1);
        wait_done(d0, "solid");
        check("solid_latency", first_we_cyc - start_edge, 2);
        finish_cmd(d0, "solid");

        // BEVEL with hand-computed spot pixels
        begin_cmd(2'd2, d0);
        wait_done(d0, "bevel");
        finish_cmd(d0, "bevel");
        check("bevel_a0", int'(mem[0]), 3);
        check("bevel_a79", int'(mem[79]), 3);
        check("bevel_a158", int'(mem[158]), 1);
        check("bevel_a153", int'(mem[153]), 3);
        check("bevel_a4133", int'(mem[4133]), 3);
        check("bevel_hi_count", hi_cnt, 508);

        // vblank gap after about 100 writes
        begin_cmd(2'd1, d0);
        wait_writes(100, "gap");
        vblank = 1'b0;
        @(negedge vclk); #1;
        w0 = wr_cnt;
        repeat (10) @(posedge vclk);
        #1;
        check("gap_no_writes", wr_cnt, w0);
        check("gap_busy", int'(busy), 1);
        vblank = 1'b1;
        wait_done(d0, "gap");
        finish_cmd(d0, "gap");

        // start with CLEAR while a HOLLOW fill is running is ignored
        begin_cmd(2'd3, d0);
        wait_writes(500, "hollow");
        pulse_start(2'd0);
        wait_done(d0, "hollow");
        finish_cmd(d0, "hollow");

        // asynchronous reset mid-fill, then a clean restart from address 0
        begin_cmd(2'd1, d0);
        wait_writes(2000, "reset");
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_we", int'(we), 0);
        check("midrst_done", int'(done), 0);
        exp_q.delete();
        @(posedge vclk); #1;
        rst = 1'b0;
        @(posedge vclk); #1;
        begin_cmd(2'd1, d0);
        wait_done(d0, "restart");
        check("restart_latency", first_we_cyc - start_edge, 2);
        finish_cmd(d0, "restart");

        // start while vblank is low for 50 cycles
        vblank = 1'b0;
        begin_cmd(2'd2, d0);
        repeat (49) @(posedge vclk);
        #1;
        check("novb_busy", int'(busy), 1);
        check("novb_we", int'(we), 0);
        check("novb_writes", wr_cnt, 0);
        vblank     = 1'b1;
        raise_edge = cyc + 1;
        wait_done(d0, "novb");
        check("novb_first_write", first_we_cyc - raise_edge, 1);
        finish_cmd(d0, "novb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
